booth_mul_arbiter: RTL and testbench
====================================

Name: booth_mul_arbiter

Overview:
- Shares one 6-stage radix-4 Booth multiplier pipeline (8x8 to 16, non-stallable, v_in/v_out qualified) among NREQ requesters.
- Round-robin arbitration; grants at most one operation per cycle into a registered issue stage.
- Tracks the requester ID through a tag shift register matched to the multiplier latency and steers each product back to its owner.
- Sits between the client blocks and the multiplier core; instantiates nothing, and connects to the core by ports.

Parameters:
- NREQ, 4, number of requesters (2..8).
- MUL_LAT, 6, multiplier latency in cycles from v_in to v_out.
- CREDITS, 2, maximum outstanding operations per requester (used only with the optional feature).

Ports:
- clk  in  1  clock; all logic is on the rising edge.
- rst  in  1  synchronous reset, active-high.
- req_valid  in  NREQ  per-requester operation valid.
- req_ready  out  NREQ  per-requester accept; one-hot or zero.
- req_a  in  8*NREQ  operand A, requester i at bits [8i+7:8i].
- req_b  in  8*NREQ  operand B, same packing.
- req_sm  in  2*NREQ  sign mode; bit1 = A signed, bit0 = B signed.
- mul_v_in  out  1  valid to multiplier.
- mul_a  out  8  operand A to multiplier.
- mul_b  out  8  operand B to multiplier.
- mul_sm  out  2  sign mode to multiplier.
- mul_p  in  16  product from multiplier.
- mul_v_out  in  1  product valid from multiplier.
- rsp_valid  out  NREQ  one-hot result strobe, single cycle.
- rsp_p  out  16  product; valid only when rsp_valid is nonzero.
- err_orphan  out  1  sticky flag: a product arrived with no matching tag.

Behaviour:
- Reset values: req_ready=0, mul_v_in=0, mul_a/mul_b/mul_sm=0, rsp_valid=0, rsp_p=0, err_orphan=0, rr pointer=0, tag pipe cleared, drop counter=MUL_LAT.
- Arbitration:
  - Combinational round-robin search over req_valid (gated by eligibility), starting at the rr pointer.
  - req_ready[i]=1 only for the winner; all zero during rst and while the drop window is active.
  - Handshake = req_valid[i] & req_ready[i].
  - On a handshake, rr pointer <= winner+1, wrapping modulo NREQ. With no handshake the pointer holds.
- Issue stage (registered):
  - On a handshake: mul_a/b/sm <= winner's operands, mul_v_in <= 1.
  - Otherwise mul_v_in <= 0 and the operands hold.
  - Throughput: 1 operation per cycle, with no bubbles under back-to-back requests.
- Tag pipe:
  - MUL_LAT entries of {valid, id[clog2(NREQ)-1:0]}.
  - Entry 0 is loaded alongside mul_v_in and shifts every cycle, so the tag exits exactly when the matching mul_v_out arrives.
- Response (registered):
  - If mul_v_out & tag_out.valid: rsp_valid <= onehot(tag_out.id), rsp_p <= mul_p.
  - Otherwise rsp_valid <= 0 and rsp_p holds.
  - Latency from handshake edge to rsp_valid high is MUL_LAT+2 = 8 cycles.
- There is no response backpressure; requesters must accept rsp_valid in the cycle it is asserted.
- Mismatches:
  - mul_v_out=1 with tag_out.valid=0 outside the drop window: err_orphan <= 1, which holds until rst.
  - tag_out.valid=1 with mul_v_out=0: the tag is discarded, err_orphan <= 1.
- Reset mid-operation: the multiplier has no reset, so in-flight products still emerge. After rst deasserts, a drop counter counts MUL_LAT cycles down to 0. While it is nonzero:
  - mul_v_out is ignored and not flagged;
  - no grants are issued.
- Simultaneous grant and response to the same requester are both legal.
- With a single active requester, it is granted every cycle.

Optional Feature:
- BOOTH_ARB_CREDIT_EN defined:
  - Per-requester outstanding counters, width clog2(CREDITS+1), reset to 0.
  - +1 on that requester's handshake, −1 on its rsp_valid; both in the same cycle leaves the counter unchanged.
  - A requester whose counter equals CREDITS is ineligible for arbitration and is skipped.
- BOOTH_ARB_CREDIT_EN undefined: no counters; every valid requester is eligible.

Test Plan:
- Reset, then requester 0 sends a=8'hFD, b=8'h05, sm=2'b11 (−3×5) → rsp_valid=4'b0001 exactly 8 cycles after the handshake, rsp_p=16'hFFF1.
- Requester 2 sends a=8'hFF, b=8'hFF, sm=2'b00 → rsp_valid=4'b0100, rsp_p=16'hFE01. Same operands with sm=2'b11 → rsp_p=16'h0001.
- All 4 requesters hold req_valid high for 12 cycles → grants follow 0,1,2,3,0,1,2,3,…; mul_v_in is high every cycle; each response is one-hot with the correct id and arrives in grant order.
- Assert rst for 1 cycle while 5 operations are in flight → no rsp_valid for the stale products, err_orphan stays 0, req_ready stays 0 for 6 cycles after rst deasserts, and normal service follows.
- Drive mul_v_out=1 with the tag pipe empty after the drop window → err_orphan=1 on the next cycle and stays high until rst.
- With BOOTH_ARB_CREDIT_EN and CREDITS=2, requester 1 holds valid continuously while the others are idle → 2 grants, req_ready[1]=0 until the first response, then 1 grant per response.

Source files
------------

// File: rtl/booth_mul_arbiter.sv
// booth_mul_arbiter
//   Shares one radix-4 Booth multiplier core (8x8 -> 16, MUL_LAT cycles,
//   non-stallable) among NREQ requesters. A round-robin arbiter grants at
//   most one operation per cycle into a registered issue stage. The
//   requester id travels down a tag shift register timed to the core, and
//   each product is steered back to its owner.
//
// Ports
//   clk, rst             clock, synchronous active-high reset
//   req_valid/req_ready  per-requester handshake (req_ready is one-hot or 0)
//   req_a, req_b         packed operands, requester i at [8i+7:8i]
//   req_sm               packed sign modes, requester i at [2i+1:2i]
//                        (bit1 = A signed, bit0 = B signed)
//   mul_v_in, mul_a,
//   mul_b, mul_sm        registered issue stage towards the core
//   mul_p, mul_v_out     product and its valid from the core
//   rsp_valid, rsp_p     registered one-hot result strobe and product
//   err_orphan           sticky: product/tag mismatch seen since reset
//
// Build option
//   BOOTH_ARB_CREDIT_EN  adds per-requester outstanding-operation counters;
//                        a requester holding CREDITS operations is skipped.

module booth_mul_arbiter #(
  parameter int unsigned NREQ    = 4,
  parameter int unsigned MUL_LAT = 6,
  parameter int unsigned CREDITS = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NREQ-1:0]      req_valid,
  output logic [NREQ-1:0]      req_ready,
  input  logic [8*NREQ-1:0]    req_a,
  input  logic [8*NREQ-1:0]    req_b,
  input  logic [2*NREQ-1:0]    req_sm,
  output logic                 mul_v_in,
  output logic [7:0]           mul_a,
  output logic [7:0]           mul_b,
  output logic [1:0]           mul_sm,
  input  logic [15:0]          mul_p,
  input  logic                 mul_v_out,
  output logic [NREQ-1:0]      rsp_valid,
  output logic [15:0]          rsp_p,
  output logic                 err_orphan
);

  localparam int unsigned ID_W   = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int unsigned DROP_W = $clog2(MUL_LAT + 1);

  // Reject configurations outside the supported range at elaboration.
  if (NREQ < 2 || NREQ > 8 || MUL_LAT < 1 || CREDITS < 1) begin : g_bad_params
    $error("booth_mul_arbiter: unsupported parameter set");
  end

  typedef struct packed {
    logic            vld;
    logic [ID_W-1:0] id;
  } tag_t;

  logic [ID_W-1:0]   rr_ptr;
  logic [ID_W-1:0]   win_id;
  logic              win_found;
  logic              grant_en;
  logic              hs;
  logic [NREQ-1:0]   eligible;
  logic [7:0]        sel_a;
  logic [7:0]        sel_b;
  logic [1:0]        sel_sm;
  logic [ID_W-1:0]   issue_id;
  tag_t              tag_pipe [MUL_LAT];
  tag_t              tag_out;
  logic [NREQ-1:0]   tag_onehot;
  logic [DROP_W-1:0] drop_cnt;
  logic              drop_active;

  // ---------------------------------------------------------------------
  // Eligibility: optionally gated by outstanding-operation credits
  // ---------------------------------------------------------------------
`ifdef BOOTH_ARB_CREDIT_EN
  localparam int unsigned CNT_W = $clog2(CREDITS + 1);

  logic [CNT_W-1:0] credit_cnt [NREQ];

  // A requester that already holds CREDITS operations is skipped.
  always_comb begin
    eligible = '0;
    for (int i = 0; i < int'(NREQ); i++) begin
      eligible[i] = req_valid[i] && (credit_cnt[i] != CNT_W'(CREDITS));
    end
  end

  // +1 per accepted operation, -1 per returned result; both cancel.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < int'(NREQ); i++) begin
        credit_cnt[i] <= '0;
      end
    end else begin
      for (int i = 0; i < int'(NREQ); i++) begin
        if ((req_valid[i] && req_ready[i]) && !rsp_valid[i]) begin
          credit_cnt[i] <= credit_cnt[i] + 1'b1;
        end else if (!(req_valid[i] && req_ready[i]) && rsp_valid[i]) begin
          credit_cnt[i] <= credit_cnt[i] - 1'b1;
        end
      end
    end
  end
`else
  assign eligible = req_valid;
`endif

  // ---------------------------------------------------------------------
  // Round-robin search starting at rr_ptr
  // ---------------------------------------------------------------------
  always_comb begin
    win_found = 1'b0;
    win_id    = '0;
    for (int k = 0; k < int'(NREQ); k++) begin
      for (int i = 0; i < int'(NREQ); i++) begin
        if (!win_found && eligible[i] &&
            (ID_W'((int'(rr_ptr) + k) % int'(NREQ)) == ID_W'(i))) begin
          win_found = 1'b1;
          win_id    = ID_W'(i);
        end
      end
    end
  end

  // No grants in reset or while stale products may still leave the core.
  assign grant_en = !rst && !drop_active;
  assign hs       = grant_en && win_found;

  always_comb begin
    req_ready = '0;
    for (int i = 0; i < int'(NREQ); i++) begin
      if (hs && (win_id == ID_W'(i))) begin
        req_ready[i] = 1'b1;
      end
    end
  end

  // Operand select for the winner.
  always_comb begin
    sel_a  = '0;
    sel_b  = '0;
    sel_sm = '0;
    for (int i = 0; i < int'(NREQ); i++) begin
      if (win_id == ID_W'(i)) begin
        sel_a  = req_a[8*i +: 8];
        sel_b  = req_b[8*i +: 8];
        sel_sm = req_sm[2*i +: 2];
      end
    end
  end

  // ---------------------------------------------------------------------
  // Issue stage and round-robin pointer
  // ---------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      mul_v_in <= 1'b0;
      mul_a    <= '0;
      mul_b    <= '0;
      mul_sm   <= '0;
      issue_id <= '0;
      rr_ptr   <= '0;
    end else begin
      mul_v_in <= hs;
      if (hs) begin
        mul_a    <= sel_a;
        mul_b    <= sel_b;
        mul_sm   <= sel_sm;
        issue_id <= win_id;
        rr_ptr   <= (win_id == ID_W'(NREQ - 1)) ? '0 : win_id + 1'b1;
      end
    end
  end

  // ---------------------------------------------------------------------
  // Tag pipe: entry 0 samples the issue register on the same edge the core
  // samples mul_v_in, so the last entry lines up with mul_v_out.
  // ---------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < int'(MUL_LAT); k++) begin
        tag_pipe[k] <= '0;
      end
    end else begin
      tag_pipe[0].vld <= mul_v_in;
      tag_pipe[0].id  <= issue_id;
      for (int k = 1; k < int'(MUL_LAT); k++) begin
        tag_pipe[k] <= tag_pipe[k-1];
      end
    end
  end

  assign tag_out = tag_pipe[MUL_LAT-1];

  always_comb begin
    tag_onehot = '0;
    for (int i = 0; i < int'(NREQ); i++) begin
      if (tag_out.id == ID_W'(i)) begin
        tag_onehot[i] = 1'b1;
      end
    end
  end

  // ---------------------------------------------------------------------
  // Drop window: the core has no reset, so products issued before reset
  // keep emerging for MUL_LAT cycles and must be ignored.
  // ---------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      drop_cnt <= DROP_W'(MUL_LAT);
    end else if (drop_active) begin
      drop_cnt <= drop_cnt - 1'b1;
    end
  end

  assign drop_active = (drop_cnt != '0);

  // ---------------------------------------------------------------------
  // Response steering and orphan detection
  // ---------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      rsp_valid  <= '0;
      rsp_p      <= '0;
      err_orphan <= 1'b0;
    end else begin
      rsp_valid <= '0;
      if (mul_v_out && tag_out.vld) begin
        rsp_valid <= tag_onehot;
        rsp_p     <= mul_p;
      end
      // Product without a tag, or tag without a product; tag is dropped.
      if (!drop_active && (mul_v_out != tag_out.vld)) begin
        err_orphan <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_booth_mul_arbiter.sv
// Directed bench for booth_mul_arbiter with a behavioural 6-cycle core.

module tb_booth_mul_arbiter;

  localparam int unsigned NREQ    = 4;
  localparam int unsigned MUL_LAT = 6;
  localparam int unsigned CREDITS = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  req_valid;
  logic [3:0]  req_ready;
  logic [31:0] req_a;
  logic [31:0] req_b;
  logic [7:0]  req_sm;
  logic        mul_v_in;
  logic [7:0]  mul_a;
  logic [7:0]  mul_b;
  logic [1:0]  mul_sm;
  logic [15:0] mul_p;
  logic        mul_v_out;
  logic [3:0]  rsp_valid;
  logic [15:0] rsp_p;
  logic        err_orphan;

  int n_cmp  = 0;
  int n_fail = 0;

  bit          inject = 1'b0;
  bit          mv [MUL_LAT];
  logic [15:0] mp [MUL_LAT];

  always #5 clk = ~clk;

  booth_mul_arbiter #(
    .NREQ    (NREQ),
    .MUL_LAT (MUL_LAT),
    .CREDITS (CREDITS)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_a      (req_a),
    .req_b      (req_b),
    .req_sm     (req_sm),
    .mul_v_in   (mul_v_in),
    .mul_a      (mul_a),
    .mul_b      (mul_b),
    .mul_sm     (mul_sm),
    .mul_p      (mul_p),
    .mul_v_out  (mul_v_out),
    .rsp_valid  (rsp_valid),
    .rsp_p      (rsp_p),
    .err_orphan (err_orphan)
  );

  // Behavioural multiplier core: no reset, v_out six cycles after v_in.
  function automatic logic [15:0] core_mul(input logic [7:0] a, input logic [7:0] b,
                                           input logic [1:0] sm);
    logic [15:0] ae;
    logic [15:0] be;
    ae = sm[1] ? {{8{a[7]}}, a} : {8'h00, a};
    be = sm[0] ? {{8{b[7]}}, b} : {8'h00, b};
    return ae * be;
  endfunction

  always @(posedge clk) begin
    mv[0] <= mul_v_in;
    mp[0] <= core_mul(mul_a, mul_b, mul_sm);
    for (int k = 1; k < int'(MUL_LAT); k++) begin
      mv[k] <= mv[k-1];
      mp[k] <= mp[k-1];
    end
  end

  assign mul_v_out = mv[MUL_LAT-1] | inject;
  assign mul_p     = mp[MUL_LAT-1];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_lane(input int i, input logic [7:0] a, input logic [7:0] b,
                          input logic [1:0] sm);
    req_a[8*i +: 8]  = a;
    req_b[8*i +: 8]  = b;
    req_sm[2*i +: 2] = sm;
  endtask

  task automatic do_reset(input int n);
    rst       = 1'b1;
    req_valid = '0;
    repeat (n) tick();
    rst = 1'b0;
  endtask

  task automatic wait_drop();
    repeat (MUL_LAT) tick();
  endtask

  task automatic test_reset();
    rst       = 1'b1;
    req_valid = 4'hF;
    tick();
    tick();
    n_cmp++; if (req_ready !== 4'b0000) begin n_fail++; $display("FAIL rst_ready: got %b want 0000", req_ready); end
    n_cmp++; if (mul_v_in !== 1'b0) begin n_fail++; $display("FAIL rst_v_in: got %b want 0", mul_v_in); end
    n_cmp++; if (mul_a !== 8'h00) begin n_fail++; $display("FAIL rst_mul_a: got %h want 00", mul_a); end
    n_cmp++; if (mul_b !== 8'h00) begin n_fail++; $display("FAIL rst_mul_b: got %h want 00", mul_b); end
    n_cmp++; if (mul_sm !== 2'b00) begin n_fail++; $display("FAIL rst_mul_sm: got %b want 00", mul_sm); end
    n_cmp++; if (rsp_valid !== 4'b0000) begin n_fail++; $display("FAIL rst_rsp_valid: got %b want 0000", rsp_valid); end
    n_cmp++; if (rsp_p !== 16'h0000) begin n_fail++; $display("FAIL rst_rsp_p: got %h want 0000", rsp_p); end
    n_cmp++; if (err_orphan !== 1'b0) begin n_fail++; $display("FAIL rst_err: got %b want 0", err_orphan); end
    rst = 1'b0;
    #1;
    for (int c = 0; c < 6; c++) begin
      n_cmp++; if (req_ready !== 4'b0000) begin n_fail++; $display("FAIL drop_ready c=%0d: got %b want 0000", c, req_ready); end
      tick();
    end
    n_cmp++; if (req_ready !== 4'b0001) begin n_fail++; $display("FAIL first_grant: got %b want 0001", req_ready); end
    req_valid = '0;
  endtask

  task automatic test_single(input int id, input logic [7:0] a, input logic [7:0] b,
                             input logic [1:0] sm, input logic [3:0] exp_oh,
                             input logic [15:0] exp_p);
    int lat;
    req_valid = '0;
    set_lane(id, a, b, sm);
    req_valid[id] = 1'b1;
    #1;
    n_cmp++; if (req_ready !== exp_oh) begin n_fail++; $display("FAIL single_ready id=%0d: got %b want %b", id, req_ready, exp_oh); end
    tick();
    req_valid = '0;
    n_cmp++; if (mul_v_in !== 1'b1) begin n_fail++; $display("FAIL single_v_in: got %b want 1", mul_v_in); end
    n_cmp++; if (mul_a !== a) begin n_fail++; $display("FAIL single_mul_a: got %h want %h", mul_a, a); end
    n_cmp++; if (mul_b !== b) begin n_fail++; $display("FAIL single_mul_b: got %h want %h", mul_b, b); end
    n_cmp++; if (mul_sm !== sm) begin n_fail++; $display("FAIL single_mul_sm: got %b want %b", mul_sm, sm); end
    lat = 1;
    while (rsp_valid === 4'b0000 && lat < 20) begin
      tick();
      lat++;
    end
    n_cmp++; if (lat != 8) begin n_fail++; $display("FAIL single_latency: got %0d want 8", lat); end
    n_cmp++; if (rsp_valid !== exp_oh) begin n_fail++; $display("FAIL single_rsp_valid: got %b want %b", rsp_valid, exp_oh); end
    n_cmp++; if (rsp_p !== exp_p) begin n_fail++; $display("FAIL single_rsp_p: got %h want %h", rsp_p, exp_p); end
    n_cmp++; if (err_orphan !== 1'b0) begin n_fail++; $display("FAIL single_err: got %b want 0", err_orphan); end
    tick();
    n_cmp++; if (rsp_valid !== 4'b0000) begin n_fail++; $display("FAIL single_strobe_len: got %b want 0000", rsp_valid); end
    n_cmp++; if (rsp_p !== exp_p) begin n_fail++; $display("FAIL single_rsp_hold: got %h want %h", rsp_p, exp_p); end
  endtask

  task automatic test_back_to_back();
    logic [15:0] exp_rr [4];
    logic [3:0]  er;
    logic [7:0]  ea;
    int          k;
    exp_rr[0] = 16'h0030;
    exp_rr[1] = 16'h0033;
    exp_rr[2] = 16'h0036;
    exp_rr[3] = 16'h0039;
    do_reset(1);
    wait_drop();
    for (int i = 0; i < 4; i++) set_lane(i, 8'(16 + i), 8'h03, 2'b00);
    for (int c = 0; c < 20; c++) begin
      req_valid = (c < 12) ? 4'hF : 4'h0;
      #1;
      if (c < 12) begin
        er = 4'b0001 << (c % 4);
        n_cmp++; if (req_ready !== er) begin n_fail++; $display("FAIL rr_ready c=%0d: got %b want %b", c, req_ready, er); end
      end
      if (c >= 1 && c <= 12) begin
        ea = 8'(16 + (c - 1) % 4);
        n_cmp++; if (mul_v_in !== 1'b1) begin n_fail++; $display("FAIL rr_v_in c=%0d: got %b want 1", c, mul_v_in); end
        n_cmp++; if (mul_a !== ea) begin n_fail++; $display("FAIL rr_mul_a c=%0d: got %h want %h", c, mul_a, ea); end
      end
      if (c == 13) begin
        n_cmp++; if (mul_v_in !== 1'b0) begin n_fail++; $display("FAIL rr_v_in_idle: got %b want 0", mul_v_in); end
      end
      if (c >= 8) begin
        k  = (c - 8) % 4;
        er = 4'b0001 << k;
        n_cmp++; if (rsp_valid !== er) begin n_fail++; $display("FAIL rr_rsp_valid c=%0d: got %b want %b", c, rsp_valid, er); end
        n_cmp++; if (rsp_p !== exp_rr[k]) begin n_fail++; $display("FAIL rr_rsp_p c=%0d: got %h want %h", c, rsp_p, exp_rr[k]); end
      end
      tick();
    end
    n_cmp++; if (rsp_valid !== 4'b0000) begin n_fail++; $display("FAIL rr_drain: got %b want 0000", rsp_valid); end
    n_cmp++; if (err_orphan !== 1'b0) begin n_fail++; $display("FAIL rr_err: got %b want 0", err_orphan); end
  endtask

  task automatic test_reset_inflight();
    int lat;
    do_reset(1);
    wait_drop();
    set_lane(0, 8'h07, 8'h09, 2'b00);
    for (int c = 0; c < 5; c++) begin
      req_valid = 4'b0001;
      #1;
      n_cmp++; if (req_ready !== 4'b0001) begin n_fail++; $display("FAIL solo_ready c=%0d: got %b want 0001", c, req_ready); end
      tick();
    end
    rst       = 1'b1;
    req_valid = '0;
    tick();
    rst       = 1'b0;
    req_valid = 4'hF;
    #1;
    for (int c = 0; c < 6; c++) begin
      n_cmp++; if (req_ready !== 4'b0000) begin n_fail++; $display("FAIL flush_ready c=%0d: got %b want 0000", c, req_ready); end
      n_cmp++; if (rsp_valid !== 4'b0000) begin n_fail++; $display("FAIL flush_rsp c=%0d: got %b want 0000", c, rsp_valid); end
      n_cmp++; if (err_orphan !== 1'b0) begin n_fail++; $display("FAIL flush_err c=%0d: got %b want 0", c, err_orphan); end
      tick();
    end
    n_cmp++; if (req_ready !== 4'b0001) begin n_fail++; $display("FAIL flush_resume: got %b want 0001", req_ready); end
    req_valid = 4'b0001;
    tick();
    req_valid = '0;
    lat = 1;
    while (rsp_valid === 4'b0000 && lat < 20) begin
      tick();
      lat++;
    end
    n_cmp++; if (lat != 8) begin n_fail++; $display("FAIL flush_latency: got %0d want 8", lat); end
    n_cmp++; if (rsp_valid !== 4'b0001) begin n_fail++; $display("FAIL flush_rsp_valid: got %b want 0001", rsp_valid); end
    n_cmp++; if (rsp_p !== 16'h003F) begin n_fail++; $display("FAIL flush_rsp_p: got %h want 003f", rsp_p); end
    n_cmp++; if (err_orphan !== 1'b0) begin n_fail++; $display("FAIL flush_err_after: got %b want 0", err_orphan); end
    repeat (2) tick();
  endtask

  task automatic test_orphan();
    n_cmp++; if (err_orphan !== 1'b0) begin n_fail++; $display("FAIL orphan_pre: got %b want 0", err_orphan); end
    inject = 1'b1;
    tick();
    inject = 1'b0;
    n_cmp++; if (err_orphan !== 1'b1) begin n_fail++; $display("FAIL orphan_set: got %b want 1", err_orphan); end
    n_cmp++; if (rsp_valid !== 4'b0000) begin n_fail++; $display("FAIL orphan_rsp: got %b want 0000", rsp_valid); end
    repeat (3) tick();
    n_cmp++; if (err_orphan !== 1'b1) begin n_fail++; $display("FAIL orphan_sticky: got %b want 1", err_orphan); end
    rst = 1'b1;
    tick();
    n_cmp++; if (err_orphan !== 1'b0) begin n_fail++; $display("FAIL orphan_clear: got %b want 0", err_orphan); end
    rst = 1'b0;
    wait_drop();
  endtask

`ifdef BOOTH_ARB_CREDIT_EN
  task automatic test_credit();
    logic [11:0] pat;
    logic [3:0]  er;
    pat = 12'b0110_0000_0011;
    do_reset(1);
    wait_drop();
    set_lane(1, 8'h05, 8'h06, 2'b00);
    for (int c = 0; c < 12; c++) begin
      req_valid = 4'b0010;
      #1;
      er = pat[c] ? 4'b0010 : 4'b0000;
      n_cmp++; if (req_ready !== er) begin n_fail++; $display("FAIL credit_ready c=%0d: got %b want %b", c, req_ready, er); end
      if (c == 8) begin
        n_cmp++; if (rsp_valid !== 4'b0010) begin n_fail++; $display("FAIL credit_rsp: got %b want 0010", rsp_valid); end
        n_cmp++; if (rsp_p !== 16'h001E) begin n_fail++; $display("FAIL credit_rsp_p: got %h want 001e", rsp_p); end
      end
      tick();
    end
    req_valid = '0;
    repeat (12) tick();
  endtask
`endif

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish within time bound");
    $fatal(1, "watchdog");
  end

  initial begin
    rst       = 1'b1;
    req_valid = '0;
    req_a     = '0;
    req_b     = '0;
    req_sm    = '0;
    test_reset();
    test_single(0, 8'hFD, 8'h05, 2'b11, 4'b0001, 16'hFFF1);
    test_single(2, 8'hFF, 8'hFF, 2'b00, 4'b0100, 16'hFE01);
    test_single(2, 8'hFF, 8'hFF, 2'b11, 4'b0100, 16'h0001);
    test_back_to_back();
    test_reset_inflight();
    test_orphan();
`ifdef BOOTH_ARB_CREDIT_EN
    test_credit();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
